// File: rtl/handshake_slave_rx.sv
// Receiving side of a 4-phase req/ack byte transfer: captures each offered byte,
// keeps a count and a wrapping sum, and parks in DONE after NUM_BYTES transfers.
module handshake_slave_rx #(
    parameter int DATA_W    = 8,
    parameter int NUM_BYTES = 4,
    parameter int ACK_HOLD  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_in,
    input  logic [DATA_W-1:0]              data_in,
    output logic                           ack_out,
    output logic                           byte_valid,
    output logic [DATA_W-1:0]              last_byte,
    output logic [$clog2(NUM_BYTES+1)-1:0] rx_count,
    output logic [DATA_W-1:0]              sum_out,
    output logic                           done_out,
    output logic [2:0]                     dbg_state
);

    // Handshake: data_in is valid while req_in is high; a byte is taken on the
    // edge that moves WAIT_REQ->ACK_HI, and ack_out then stays high for at least
    // ACK_HOLD+1 cycles and until req_in is seen low, before dropping for one cycle.

    localparam int CNT_W  = $clog2(NUM_BYTES + 1);
    localparam int HOLD_W = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;

    typedef enum logic [2:0] {
        WAIT_REQ    = 3'd0,
        ACK_HI      = 3'd1,
        WAIT_REQ_LO = 3'd2,
        DROP_ACK    = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold;

    assign dbg_state = state;

    // ack_out and done_out are updated alongside state so they always equal its decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_REQ;
            ack_out    <= 1'b0;
            byte_valid <= 1'b0;
            done_out   <= 1'b0;
            last_byte  <= '0;
            rx_count   <= '0;
            sum_out    <= '0;
            hold       <= '0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                WAIT_REQ: begin
                    if (req_in) begin
                        last_byte  <= data_in;
                        sum_out    <= sum_out + data_in;
                        rx_count   <= rx_count + CNT_W'(1);
                        byte_valid <= 1'b1;
                        hold       <= '0;
                        ack_out    <= 1'b1;
                        state      <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    hold <= hold + HOLD_W'(1);
                    if (hold == HOLD_W'(ACK_HOLD - 1)) begin
                        state <= WAIT_REQ_LO;
                    end
                end
                WAIT_REQ_LO: begin
                    if (!req_in) begin
                        ack_out <= 1'b0;
                        state   <= DROP_ACK;
                    end
                end
                DROP_ACK: begin
                    if (rx_count == CNT_W'(NUM_BYTES)) begin
                        done_out <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= WAIT_REQ;
                    end
                end
                DONE: begin
                    done_out <= 1'b1;
                end
                default: begin
                    ack_out  <= 1'b0;
                    done_out <= 1'b0;
                    state    <= WAIT_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_slave_rx.sv
// Directed bench for handshake_slave_rx: a vector table for the cycle-exact
// handshake, then driver-based sequences for full runs, slow master, reset and DONE.
module tb_handshake_slave_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] data;
    logic       ack, bv, done;
    logic [7:0] last_byte, sum;
    logic [2:0] cnt;
    logic [2:0] st;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    bit   mon_en = 1'b0;
    int   n_pulses = 0;

    localparam logic [2:0] S_WAIT = 3'd0, S_ACK = 3'd1, S_WLO = 3'd2, S_DROP = 3'd3, S_DONE = 3'd4;

    handshake_slave_rx #(.DATA_W(8), .NUM_BYTES(4), .ACK_HOLD(2)) dut (
        .clk(clk), .rst(rst), .req_in(req), .data_in(data),
        .ack_out(ack), .byte_valid(bv), .last_byte(last_byte), .rx_count(cnt),
        .sum_out(sum), .done_out(done), .dbg_state(st)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; data = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // byte_valid monitor: each pulse must match the next byte the driver offered.
    always @(negedge clk) begin
        if (mon_en && bv) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_byte_valid", {24'h0, last_byte}, 32'hFFFF_FFFF);
            end else begin
                check("byte_order", {24'h0, last_byte}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Master driver: raise req, hold it 'extra' cycles after ack is seen, then
    // drop it and wait for ack to fall. Returns the number of ack-high cycles.
    task automatic send_byte(input logic [7:0] d, input int extra, output int ack_cycles);
        int t;
        ack_cycles = 0;
        exp_q.push_back(d);
        req = 1'b1; data = d;
        t = 0;
        do begin tick(); t++; end while (!ack && t < 20);
        check("ack_rise_timeout", {31'h0, ack}, 32'h1);
        ack_cycles = 1;
        repeat (extra) begin
            tick();
            if (ack) ack_cycles++;
        end
        req = 1'b0; data = $urandom_range(0, 255);
        t = 0;
        while (ack && t < 40) begin
            tick(); t++;
            if (ack) ack_cycles++;
        end
        check("ack_fall_timeout", {31'h0, ack}, 32'h0);
    endtask

    typedef struct {
        logic       req;
        logic [7:0] data;
        logic [2:0] st;
        logic       ack;
        logic       bv;
        logic [7:0] last;
        logic [2:0] cnt;
        logic [7:0] sum;
        logic       done;
    } vec_t;

    vec_t vecs[24];

    initial begin
        int ac;
        // Inputs applied before an edge; expected outputs just after it.
        vecs[0]  = '{1'b0, 8'h00, S_WAIT, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'hA0, S_ACK,  1'b1, 1'b1, 8'hA0, 3'd1, 8'hA0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, S_ACK,  1'b1, 1'b0, 8'hA0, 3'd1, 8'hA0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, S_WLO,  1'b1, 1'b0, 8'hA0, 3'd1, 8'hA0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, S_DROP, 1'b0, 1'b0, 8'hA0, 3'd1, 8'hA0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, S_WAIT, 1'b0, 1'b0, 8'hA0, 3'd1, 8'hA0, 1'b0};
        vecs[6]  = '{1'b1, 8'h55, S_ACK,  1'b1, 1'b1, 8'h55, 3'd2, 8'hF5, 1'b0};
        vecs[7]  = '{1'b1, 8'hFF, S_ACK,  1'b1, 1'b0, 8'h55, 3'd2, 8'hF5, 1'b0};
        vecs[8]  = '{1'b1, 8'hFF, S_WLO,  1'b1, 1'b0, 8'h55, 3'd2, 8'hF5, 1'b0};
        vecs[9]  = '{1'b1, 8'hFF, S_WLO,  1'b1, 1'b0, 8'h55, 3'd2, 8'hF5, 1'b0};
        vecs[10] = '{1'b0, 8'hFF, S_DROP, 1'b0, 1'b0, 8'h55, 3'd2, 8'hF5, 1'b0};
        vecs[11] = '{1'b0, 8'h00, S_WAIT, 1'b0, 1'b0, 8'h55, 3'd2, 8'hF5, 1'b0};
        vecs[12] = '{1'b1, 8'h10, S_ACK,  1'b1, 1'b1, 8'h10, 3'd3, 8'h05, 1'b0};
        vecs[13] = '{1'b1, 8'h10, S_ACK,  1'b1, 1'b0, 8'h10, 3'd3, 8'h05, 1'b0};
        vecs[14] = '{1'b1, 8'h10, S_WLO,  1'b1, 1'b0, 8'h10, 3'd3, 8'h05, 1'b0};
        vecs[15] = '{1'b0, 8'h10, S_DROP, 1'b0, 1'b0, 8'h10, 3'd3, 8'h05, 1'b0};
        vecs[16] = '{1'b1, 8'h20, S_WAIT, 1'b0, 1'b0, 8'h10, 3'd3, 8'h05, 1'b0};
        vecs[17] = '{1'b1, 8'h20, S_ACK,  1'b1, 1'b1, 8'h20, 3'd4, 8'h25, 1'b0};
        vecs[18] = '{1'b0, 8'h00, S_ACK,  1'b1, 1'b0, 8'h20, 3'd4, 8'h25, 1'b0};
        vecs[19] = '{1'b0, 8'h00, S_WLO,  1'b1, 1'b0, 8'h20, 3'd4, 8'h25, 1'b0};
        vecs[20] = '{1'b0, 8'h00, S_DROP, 1'b0, 1'b0, 8'h20, 3'd4, 8'h25, 1'b0};
        vecs[21] = '{1'b0, 8'h00, S_DONE, 1'b0, 1'b0, 8'h20, 3'd4, 8'h25, 1'b1};
        vecs[22] = '{1'b1, 8'h11, S_DONE, 1'b0, 1'b0, 8'h20, 3'd4, 8'h25, 1'b1};
        vecs[23] = '{1'b0, 8'h00, S_DONE, 1'b0, 1'b0, 8'h20, 3'd4, 8'h25, 1'b1};

        // Reset values, sampled while rst is still asserted and after release.
        rst = 1'b1; req = 1'b1; data = 8'hEE;
        repeat (2) tick();
        check("rst_state", {29'h0, st}, {29'h0, S_WAIT});
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_bv", {31'h0, bv}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_last", {24'h0, last_byte}, 32'h0);
        check("rst_cnt", {29'h0, cnt}, 32'h0);
        check("rst_sum", {24'h0, sum}, 32'h0);
        rst = 1'b0; req = 1'b0; data = 8'h00;

        // Idle: nothing may move with req low.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ack", {31'h0, ack}, 32'h0);
            check("idle_cnt", {29'h0, cnt}, 32'h0);
            check("idle_sum", {24'h0, sum}, 32'h0);
            check("idle_done", {31'h0, done}, 32'h0);
        end

        // Vector table: single A0 transfer, data change under ack, slow release,
        // req held through DROP_ACK, reaching DONE, and a req pulse after DONE.
        for (int i = 0; i < 24; i++) begin
            req = vecs[i].req; data = vecs[i].data;
            tick();
            check($sformatf("v%0d_state", i), {29'h0, st}, {29'h0, vecs[i].st});
            check($sformatf("v%0d_ack", i), {31'h0, ack}, {31'h0, vecs[i].ack});
            check($sformatf("v%0d_bv", i), {31'h0, bv}, {31'h0, vecs[i].bv});
            check($sformatf("v%0d_last", i), {24'h0, last_byte}, {24'h0, vecs[i].last});
            check($sformatf("v%0d_cnt", i), {29'h0, cnt}, {29'h0, vecs[i].cnt});
            check($sformatf("v%0d_sum", i), {24'h0, sum}, {24'h0, vecs[i].sum});
            check($sformatf("v%0d_done", i), {31'h0, done}, {31'h0, vecs[i].done});
        end

        // Full run A0..A3: sum 0x286 wraps to 0x86.
        do_reset();
        mon_en = 1'b1; n_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hA0 + 8'(i), 0, ac);
            check("full_ack_cycles", ac, 32'd3);
        end
        check("full_last_drop_state", {29'h0, st}, {29'h0, S_DROP});
        check("full_done_at_drop", {31'h0, done}, 32'h0);
        tick();
        check("full_done", {31'h0, done}, 32'h1);
        check("full_sum", {24'h0, sum}, 32'h86);
        check("full_cnt", {29'h0, cnt}, 32'd4);
        check("full_pulses", n_pulses, 32'd4);
        check("full_queue_empty", exp_q.size(), 32'd0);

        // Slow master: req held 12 cycles after ack rises.
        do_reset();
        n_pulses = 0;
        send_byte(8'h3C, 12, ac);
        check("slow_ack_cycles", ac, 32'd13);
        repeat (3) tick();
        check("slow_cnt", {29'h0, cnt}, 32'd1);
        check("slow_pulses", n_pulses, 32'd1);
        check("slow_last", {24'h0, last_byte}, 32'h3C);

        // Reset during WAIT_REQ_LO of the third byte, then a fresh run.
        do_reset();
        send_byte(8'h07, 0, ac);
        send_byte(8'h09, 0, ac);
        exp_q.push_back(8'h0B);
        req = 1'b1; data = 8'h0B;
        for (int t = 0; t < 20 && st != S_WLO; t++) tick();
        check("mid_reached_wlo", {29'h0, st}, {29'h0, S_WLO});
        rst = 1'b1; req = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_ack", {31'h0, ack}, 32'h0);
        check("mid_rst_cnt", {29'h0, cnt}, 32'h0);
        check("mid_rst_sum", {24'h0, sum}, 32'h0);
        check("mid_rst_state", {29'h0, st}, {29'h0, S_WAIT});
        for (int i = 1; i <= 4; i++) send_byte(8'(i), $urandom_range(0, 3), ac);
        tick();
        check("fresh_done", {31'h0, done}, 32'h1);
        check("fresh_sum", {24'h0, sum}, 32'h0A);
        check("fresh_cnt", {29'h0, cnt}, 32'd4);

        // Post-DONE request must be ignored.
        req = 1'b1; data = 8'h11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pd_ack", {31'h0, ack}, 32'h0);
            check("pd_bv", {31'h0, bv}, 32'h0);
            check("pd_cnt", {29'h0, cnt}, 32'd4);
            check("pd_sum", {24'h0, sum}, 32'h0A);
            check("pd_last", {24'h0, last_byte}, 32'h04);
            check("pd_done", {31'h0, done}, 32'h1);
        end
        req = 1'b0;
        tick();
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_slave_rx.md
Name: handshake_slave_rx

Overview:
- Receiving end of the 4-phase req/ack byte-transfer protocol.
- Watches req_in and captures data_in on each request.
- Drives ack_out through the full handshake: raise ack, hold it, wait for req to fall, drop ack.
- Counts received bytes, keeps a running 8-bit sum, and signals done after NUM_BYTES transfers. Sits opposite the handshake master in the problemSet_4 transfer pair.

Parameters:
- DATA_W, 8, width of data_in, last_byte and sum_out.
- NUM_BYTES, 4, number of transfers before entering DONE; must be >= 1.
- ACK_HOLD, 2, minimum cycles ack_out stays high before req_in low is honoured; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_in  input  1  request from master; data_in is valid while high
- data_in  input  DATA_W  byte offered by master
- ack_out  output  1  acknowledge to master, registered state decode
- byte_valid  output  1  one-cycle pulse: last_byte updated this cycle
- last_byte  output  DATA_W  most recently captured byte
- rx_count  output  $clog2(NUM_BYTES+1)  bytes received since reset
- sum_out  output  DATA_W  running sum of captured bytes, mod 2^DATA_W
- done_out  output  1  high in DONE state

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. At an edge with rst=1:
  - state=WAIT_REQ
  - ack_out=0, byte_valid=0, done_out=0
  - last_byte=0, rx_count=0, sum_out=0
  - hold counter=0
- rst overrides everything, including mid-handshake. ack_out is 0 from the cycle after the reset edge.
- States:
  - WAIT_REQ: ack=0. If req_in=1 at edge: last_byte<=data_in; sum_out<=sum_out+data_in (wraps); rx_count<=rx_count+1; byte_valid<=1; hold counter<=0; go ACK_HI.
  - ACK_HI: ack=1. Hold counter increments each cycle. When counter reaches ACK_HOLD-1 at an edge, go WAIT_REQ_LO; req_in is ignored here.
  - WAIT_REQ_LO: ack=1. If req_in=0 at edge, go DROP_ACK; otherwise stay.
  - DROP_ACK: ack=0, one cycle. Go DONE if rx_count==NUM_BYTES, else WAIT_REQ.
  - DONE: ack=0, done_out=1, terminal until rst. req_in is ignored; no capture, count or sum change.
- Timing rules:
  - Latency from req_in sampled high to ack_out high is 1 cycle.
  - ack_out stays high for max(ACK_HOLD+1, cycles until req low is sampled) cycles.
  - byte_valid is high exactly one cycle per transfer: the first ACK_HI cycle.
  - Data is sampled only on the WAIT_REQ->ACK_HI edge. Later data_in changes do not affect last_byte or sum_out.
- Boundary conditions:
  - req_in held high through DROP_ACK (master violation): DROP_ACK->WAIT_REQ transition happens, and req_in=1 is then captured as a new transfer next edge. No error flag.
  - req_in falling during ACK_HI is legal. It is honoured on the first WAIT_REQ_LO cycle.
  - rx_count saturates structurally: DONE is entered at NUM_BYTES and no further capture occurs.
  - An unused state encoding recovers to WAIT_REQ.
  - All outputs are registered or pure state decodes. There is no combinational path from req_in to ack_out.

Test Plan:
- Reset then idle, req_in=0 for 10 cycles -> ack_out=0, rx_count=0, sum_out=0, done_out=0 throughout.
- Single transfer: data_in=8'hA0, req_in rises at cycle 5 and drops the cycle after ack is seen, ACK_HOLD=2:
  - ack_out high cycles 6-8, low at 9 (DROP_ACK)
  - byte_valid pulse at cycle 6
  - last_byte=8'hA0, rx_count=1
- Full run against the handshake master sending A0,A1,A2,A3:
  - exactly 4 byte_valid pulses, in order A0..A3
  - sum_out=8'h86 (wrap of 0x286), rx_count=4
  - done_out=1 one cycle after the final DROP_ACK
- Slow master: req_in held high 12 cycles after ack rises -> ack_out stays high until the edge after req_in falls, then 0; no extra capture.
- data_in changes from 8'h55 to 8'hFF while ack_out is high -> last_byte remains 8'h55, sum unchanged by 8'hFF.
- Reset mid-handshake, rst=1 during WAIT_REQ_LO after 2 bytes:
  - next cycle: ack_out=0, rx_count=0, sum_out=0, state WAIT_REQ
  - a following fresh 4-byte run completes with done_out=1
- Post-DONE: pulse req_in with data 8'h11 -> no ack_out, no byte_valid, counters frozen.
